inv_mixcolumns_seq: RTL



---
 rtl/inv_mixcolumns_seq_if.sv | 24 ++
 rtl/inv_mixcolumns_seq.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/inv_mixcolumns_seq_if.sv
// Handshake bundle for the iterative InvMixColumns engine.
// INV_MIXCOL_FWD_EN adds the per-state fwd select carried alongside state_in.
interface inv_mixcolumns_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic         busy;
`ifdef INV_MIXCOL_FWD_EN
  logic         fwd;

  modport master (output in_valid, state_in, out_ready, fwd,
                  input  in_ready, out_valid, state_out, busy);
  modport slave  (input  in_valid, state_in, out_ready, fwd,
                  output in_ready, out_valid, state_out, busy);
`else
  modport master (output in_valid, state_in, out_ready,
                  input  in_ready, out_valid, state_out, busy);
  modport slave  (input  in_valid, state_in, out_ready,
                  output in_ready, out_valid, state_out, busy);
`endif
endinterface

// File: rtl/inv_mixcolumns_seq.sv
// Iterative AES InvMixColumns: one column per clock through a shared multiplier.
// INV_MIXCOL_FWD_EN adds a fwd input that selects forward MixColumns per state.
module inv_mixcolumns_seq (
  input logic                  clk,
  input logic                  rst,
  inv_mixcolumns_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e       state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic [127:0] work_q, work_d;
  logic         fwd_q, fwd_d;

  logic         in_ready, out_valid, busy_o, load;
  logic         fwd_in;
  logic [31:0]  col_in, col_out;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m2(input logic [7:0] x);
    return xt(x);
  endfunction
  function automatic logic [7:0] m3(input logic [7:0] x);
    return xt(x) ^ x;
  endfunction
  function automatic logic [7:0] m9(input logic [7:0] x);
    return xt(xt(xt(x))) ^ x;
  endfunction
  function automatic logic [7:0] mb(input logic [7:0] x);
    return xt(xt(xt(x))) ^ xt(x) ^ x;
  endfunction
  function automatic logic [7:0] md(input logic [7:0] x);
    return xt(xt(xt(x))) ^ xt(xt(x)) ^ x;
  endfunction
  function automatic logic [7:0] me(input logic [7:0] x);
    return xt(xt(xt(x))) ^ xt(xt(x)) ^ xt(x);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c, input logic fwd);
    logic [7:0] b0, b1, b2, b3;
    {b0, b1, b2, b3} = c;
    if (fwd)
      return {m2(b0) ^ m3(b1) ^ b2     ^ b3,
              b0     ^ m2(b1) ^ m3(b2) ^ b3,
              b0     ^ b1     ^ m2(b2) ^ m3(b3),
              m3(b0) ^ b1     ^ b2     ^ m2(b3)};
    else
      return {me(b0) ^ mb(b1) ^ md(b2) ^ m9(b3),
              m9(b0) ^ me(b1) ^ mb(b2) ^ md(b3),
              md(b0) ^ m9(b1) ^ me(b2) ^ mb(b3),
              mb(b0) ^ md(b1) ^ m9(b2) ^ me(b3)};
  endfunction

`ifdef INV_MIXCOL_FWD_EN
  assign fwd_in = bus.fwd;
`else
  assign fwd_in = 1'b0;
`endif

  // Single shared column multiplier, steered by the column counter
  always_comb begin
    col_in = work_q[127:96];
    case (col_q)
      2'd0: col_in = work_q[127:96];
      2'd1: col_in = work_q[95:64];
      2'd2: col_in = work_q[63:32];
      2'd3: col_in = work_q[31:0];
      default: col_in = work_q[127:96];
    endcase
  end

  assign col_out = mix_col(col_in, fwd_q);

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    work_d    = work_q;
    fwd_d     = fwd_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy_o    = 1'b0;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        load     = bus.in_valid;
      end
      BUSY: begin
        busy_o = 1'b1;
        case (col_q)
          2'd0: work_d[127:96] = col_out;
          2'd1: work_d[95:64]  = col_out;
          2'd2: work_d[63:32]  = col_out;
          2'd3: work_d[31:0]   = col_out;
          default: work_d = work_q;
        endcase
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        // Ready follows out_ready: a new state only enters as the old one leaves
        in_ready  = bus.out_ready;
        if (bus.out_ready) begin
          load    = bus.in_valid;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      work_d  = bus.state_in;
      col_d   = 2'd0;
      fwd_d   = fwd_in;
      state_d = BUSY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      work_q  <= 128'h0;
      fwd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      work_q  <= work_d;
      fwd_q   <= fwd_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy_o;
  assign bus.state_out = work_q;

endmodule
